isp_gray_stage: RTL and testbench

ISP_GRAY_STAGE -- requirements
Module: isp_gray_stage

---
 rtl/isp_pkg.sv | 44 ++++
 rtl/isp_gray_stage_if.sv | 38 +++
 rtl/rgb565_luma.sv | 67 ++++++
 rtl/isp_gray_stage.sv | 174 +++++++++++++++++
 tb/tb_isp_gray_stage.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : isp_pkg                                                      |
// | Brief   : Shared constants, types and helpers for the grayscale stage. |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package isp_pkg;

  // BT.601-style luma weights scaled by 256 (they sum to exactly 256).
  localparam logic [7:0] LUMA_COEF_R = 8'd77;
  localparam logic [7:0] LUMA_COEF_G = 8'd150;
  localparam logic [7:0] LUMA_COEF_B = 8'd29;

  // Latency from an accepted input pixel to the output strobe.
  localparam int unsigned PIPE_DEPTH = 3;

  // Width of the bad-frame counter.
  localparam int unsigned ERR_CNT_W = 8;

  // Luma accumulator width: 256 * 255 = 65280 fits without overflow.
  localparam int unsigned LUMA_ACC_W = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // RGB565 -> RGB888 by replicating each channel's MSBs into the new LSBs.
  function automatic rgb888_t expand_rgb565(input logic [15:0] px);
    rgb888_t c;
    c.r = {px[15:11], px[15:13]};
    c.g = {px[10:5],  px[10:9]};
    c.b = {px[4:0],   px[4:2]};
    return c;
  endfunction

  // Pack an 8-bit luma value back into RGB565 with equal channels.
  function automatic logic [15:0] luma_to_rgb565(input logic [7:0] y);
    return {y[7:3], y[7:2], y[7:3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/isp_gray_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : isp_gray_stage_if                                            |
// | Brief   : Pixel stream bundle for the grayscale stage: camera-side     |
// |           input stream and DDR-write-side output stream.               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface isp_gray_stage_if;

  logic        in_vs;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_vs;
  logic        out_valid;
  logic [15:0] out_data;

  // Environment side: sources the camera stream, sinks the processed one.
  modport master (
    output in_vs,
    output in_valid,
    output in_data,
    input  out_vs,
    input  out_valid,
    input  out_data
  );

  // Processing stage side.
  modport slave (
    input  in_vs,
    input  in_valid,
    input  in_data,
    output out_vs,
    output out_valid,
    output out_data
  );

endinterface
`default_nettype wire

// File: rtl/rgb565_luma.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rgb565_luma                                                  |
// | Brief   : Two registered stages of luma arithmetic: channel expand and |
// |           multiply, then sum into a 16-bit accumulator. Y = acc >> 8.  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rgb565_luma
  import isp_pkg::*;
(
  input  wire         Clk,
  input  wire         Rst_n,
  input  wire         valid_i,
  input  wire  [15:0] data_i,
  output logic        valid_o,
  output logic [7:0]  y_o
);

  rgb888_t               rgb_w;
  logic [LUMA_ACC_W-1:0] acc_w;

  logic                  v1_q;
  logic [LUMA_ACC_W-1:0] prod_r_q;
  logic [LUMA_ACC_W-1:0] prod_g_q;
  logic [LUMA_ACC_W-1:0] prod_b_q;

  logic                  v2_q;
  logic [LUMA_ACC_W-1:0] acc_q;

  assign rgb_w = expand_rgb565(data_i);
  assign acc_w = prod_r_q + prod_g_q + prod_b_q;

  // Stage 1: expand to 8 bits per channel and form the weighted products.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v1_q     <= 1'b0;
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        prod_r_q <= LUMA_ACC_W'(LUMA_COEF_R) * LUMA_ACC_W'(rgb_w.r);
        prod_g_q <= LUMA_ACC_W'(LUMA_COEF_G) * LUMA_ACC_W'(rgb_w.g);
        prod_b_q <= LUMA_ACC_W'(LUMA_COEF_B) * LUMA_ACC_W'(rgb_w.b);
      end
    end
  end

  // Stage 2: accumulate; truncation (no rounding) happens on the shift below.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v2_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        acc_q <= acc_w;
      end
    end
  end

  assign valid_o = v2_q;
  assign y_o     = 8'(acc_q >> 8);

endmodule
`default_nettype wire

// File: rtl/isp_gray_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : isp_gray_stage                                               |
// | Brief   : RGB565 -> grayscale RGB565 stream stage with frame-locked    |
// |           mode switching and a fixed 3-cycle latency. Define           |
// |           ISP_GRAY_FRAME_CHECK_EN to build in the frame geometry       |
// |           checker (frame_err / err_cnt); otherwise both read 0.        |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module isp_gray_stage
  import isp_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 1280,
  parameter int unsigned IMAGE_HEIGHT = 720
) (
  input  wire                  Clk,
  input  wire                  Rst_n,
  input  wire                  gray_en,
  isp_gray_stage_if.slave      px,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                  vs_prev_q;
  logic                  started_q;
  logic                  mode_q;
  logic                  frame_start_w;
  logic                  accept_w;

  logic [PIPE_DEPTH-1:0] vs_dly_q;
  logic [15:0]           raw1_q;
  logic [15:0]           raw2_q;
  logic                  mode1_q;
  logic                  mode2_q;

  logic                  luma_v_w;
  logic [7:0]            luma_y_w;

  logic                  out_valid_q;
  logic [15:0]           out_data_q;

  // A frame starts on the rising edge of vs. Pixels are only taken while vs
  // is low and once a frame has started since reset.
  assign frame_start_w = px.in_vs & ~vs_prev_q;
  assign accept_w      = px.in_valid & ~px.in_vs & started_q;

  // Frame-start detection, frame-locked mode latch and first-frame gate.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vs_prev_q <= 1'b0;
      started_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      vs_prev_q <= px.in_vs;
      if (frame_start_w) begin
        started_q <= 1'b1;
        mode_q    <= gray_en;
      end
    end
  end

  // Frame sync travels through the same number of stages as the pixels.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vs_dly_q <= '0;
    end else begin
      vs_dly_q <= {vs_dly_q[PIPE_DEPTH-2:0], px.in_vs};
    end
  end

  // Raw pixel and its mode ride alongside the luma stages, so a pixel keeps
  // the mode of the frame it was accepted in even across a frame boundary.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      raw1_q  <= '0;
      raw2_q  <= '0;
      mode1_q <= 1'b0;
      mode2_q <= 1'b0;
    end else begin
      if (accept_w) begin
        raw1_q  <= px.in_data;
        mode1_q <= mode_q;
      end
      raw2_q  <= raw1_q;
      mode2_q <= mode1_q;
    end
  end

  rgb565_luma u_luma (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .valid_i (accept_w),
    .data_i  (px.in_data),
    .valid_o (luma_v_w),
    .y_o     (luma_y_w)
  );

  // Stage 3: pick grayscale or pass-through and register the output pixel.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= luma_v_w;
      if (luma_v_w) begin
        out_data_q <= mode2_q ? luma_to_rgb565(luma_y_w) : raw2_q;
      end
    end
  end

  assign px.out_vs    = vs_dly_q[PIPE_DEPTH-1];
  assign px.out_valid = out_valid_q;
  assign px.out_data  = out_data_q;

`ifdef ISP_GRAY_FRAME_CHECK_EN
  localparam int unsigned      COL_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned      ROW_W    = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(IMAGE_HEIGHT);

  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic                 ovf_q;
  logic                 frame_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 geom_bad_w;

  // A complete frame leaves the counters parked at (HEIGHT, 0) with no
  // pixels seen beyond the last line.
  assign geom_bad_w = (row_q != ROW_FULL) || (col_q != '0) || ovf_q;

  // Geometry counters, judged and cleared at each frame start; the first
  // frame start after reset has no preceding frame to judge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      frame_err_q <= 1'b0;
      if (frame_start_w) begin
        col_q <= '0;
        row_q <= '0;
        ovf_q <= 1'b0;
        if (started_q && geom_bad_w) begin
          frame_err_q <= 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
          end
        end
      end else if (accept_w) begin
        if (row_q == ROW_FULL) begin
          ovf_q <= 1'b1;
        end else if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_err = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isp_gray_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_isp_gray_stage                                            |
// | Brief   : Self-checking bench for isp_gray_stage: fixed vectors,       |
// |           hand-written corner sequences and random frames compared     |
// |           against a behavioural model every cycle.                     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_isp_gray_stage;

  localparam int W = 8;
  localparam int H = 4;

`ifdef ISP_GRAY_FRAME_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       gray_en = 1'b0;
  logic       frame_err;
  logic [7:0] err_cnt;

  isp_gray_stage_if bus ();

  isp_gray_stage #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .gray_en   (gray_en),
    .px        (bus),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        vs;
    logic        valid;
    logic [15:0] data;
  } beat_t;

  beat_t pipe[$];        // outputs expected on the next three sampling edges
  bit    m_prev_vs;
  bit    m_have_frame;
  bit    m_mode;
  int    m_count;        // pixels accepted in the current frame
  int    m_errs;
  bit    exp_ferr;
  bit    g_req = 1'b0;   // gray_en value to drive on the next step

  logic        obs_ferr;
  logic [7:0]  obs_cnt;
  logic        obs_valid;
  logic [15:0] obs_data;
  int          valid_seen;

  // Luma straight from the arithmetic definition.
  function automatic logic [15:0] ref_gray(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8, y;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    y  = (77 * r8 + 150 * g8 + 29 * b8) / 256;
    return 16'((y / 8) * 2048 + (y / 4) * 32 + (y / 8));
  endfunction

  // One clock: compare outputs, then drive new inputs and advance the model.
  task automatic step(input bit rstn, input bit vs, input bit valid, input logic [15:0] data);
    beat_t e;
    beat_t nb;
    bit    fs;
    @(negedge clk);
    e         = pipe.pop_front();
    obs_ferr  = frame_err;
    obs_cnt   = err_cnt;
    obs_valid = bus.out_valid;
    obs_data  = bus.out_data;
    check("out_vs", bus.out_vs, e.vs);
    check("out_valid", bus.out_valid, e.valid);
    if (e.valid) check("out_data", bus.out_data, e.data);
    check("frame_err", frame_err, exp_ferr);
    check("err_cnt", err_cnt, m_errs);
    if (bus.out_valid) valid_seen++;

    rst_n        = rstn;
    gray_en      = g_req;
    bus.in_vs    = vs;
    bus.in_valid = valid;
    bus.in_data  = data;

    exp_ferr = 1'b0;
    if (!rstn) begin
      pipe = {};
      repeat (3) pipe.push_back('0);
      m_prev_vs    = 1'b0;
      m_have_frame = 1'b0;
      m_mode       = 1'b0;
      m_count      = 0;
      m_errs       = 0;
    end else begin
      fs        = vs && !m_prev_vs;
      m_prev_vs = vs;
      if (fs) begin
        if (CHK_EN && m_have_frame && m_count != W * H) begin
          exp_ferr = 1'b1;
          if (m_errs < 255) m_errs++;
        end
        m_have_frame = 1'b1;
        m_mode       = g_req;
        m_count      = 0;
      end
      nb.vs    = vs;
      nb.valid = valid && !vs && m_have_frame;
      nb.data  = m_mode ? ref_gray(data) : data;
      if (nb.valid) m_count++;
      pipe.push_back(nb);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  // vs high for len cycles with junk pixels that must be dropped.
  task automatic vs_pulse(input int len);
    repeat (len) step(1'b1, 1'b1, 1'($urandom % 2), 16'($urandom));
  endtask

  task automatic send_frame(input int npix, input bit toggle);
    vs_pulse(2);
    for (int k = 0; k < npix; k++) begin
      if ($urandom_range(3) == 0) step(1'b1, 1'b0, 1'b0, 16'($urandom));
      if (toggle && k == npix / 2) g_req = ~g_req;
      step(1'b1, 1'b0, 1'b1, 16'($urandom));
    end
    idle(2);
  endtask

  // One pixel; output must appear exactly three cycles later.
  task automatic pix_expect(input string name, input logic [15:0] din, input logic [15:0] dout);
    step(1'b1, 1'b0, 1'b1, din);
    idle(1); check({name, "_lat1"}, obs_valid, 0);
    idle(1); check({name, "_lat2"}, obs_valid, 0);
    idle(1); check({name, "_valid"}, obs_valid, 1);
    check({name, "_data"}, obs_data, dout);
  endtask

  // Raise vs and look at the checker's reaction on the following cycles.
  task automatic close_frame(input string name, input bit ferr, input int cnt);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check({name, "_ferr"}, obs_ferr, ferr);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check({name, "_ferr_1cyc"}, obs_ferr, 0);
    check({name, "_cnt"}, obs_cnt, cnt);
    idle(1);
  endtask

  typedef struct packed {
    logic        g;
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Grayscale values: Y=255 -> FFFF, Y=76 -> {01001,010011,01001},
    // Y=149 -> 94B2, Y=28 -> 18E3, Y=130 -> 8410.
    tbl = '{
      '{1'b0, 16'h1234, 16'h1234},
      '{1'b0, 16'hF800, 16'hF800},
      '{1'b1, 16'hFFFF, 16'hFFFF},
      '{1'b1, 16'hF800, 16'h4A69},
      '{1'b1, 16'h07E0, 16'h94B2},
      '{1'b1, 16'h001F, 16'h18E3},
      '{1'b1, 16'h0000, 16'h0000},
      '{1'b1, 16'h8410, 16'h8410},
      '{1'b0, 16'hA5A5, 16'hA5A5}
    };
    bus.in_vs    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0;
    repeat (3) pipe.push_back('0);
    exp_ferr   = 1'b0;
    m_errs     = 0;
    valid_seen = 0;

    // Reset state.
    step(1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b1, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("rst_out_vs", bus.out_vs, 0);
    check("rst_out_valid", obs_valid, 0);
    check("rst_out_data", obs_data, 0);
    check("rst_frame_err", obs_ferr, 0);
    check("rst_err_cnt", obs_cnt, 0);

    // Pixels before the first frame start are dropped.
    valid_seen = 0;
    repeat (5) step(1'b1, 1'b0, 1'b1, 16'($urandom));
    idle(3);
    check("pre_frame_drop", valid_seen, 0);

    // Fixed vectors, each in its own frame so gray_en is latched.
    for (int i = 0; i < 9; i++) begin
      g_req = tbl[i].g;
      vs_pulse(1);
      idle(1);
      pix_expect($sformatf("tbl%0d", i), tbl[i].din, tbl[i].dout);
    end

    // gray_en toggled mid-frame takes effect only at the next frame start.
    g_req = 1'b0;
    vs_pulse(1);
    pix_expect("mode_before", 16'hF800, 16'hF800);
    g_req = 1'b1;
    idle(2);
    pix_expect("mode_midframe", 16'hF800, 16'hF800);
    vs_pulse(1);
    pix_expect("mode_after", 16'hF800, 16'h4A69);

    // Correct frames: pass-through, then random modes with mid-frame toggles.
    do_reset();
    g_req = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(W * H, 1'b0);
    for (int f = 0; f < 4; f++) begin
      g_req = 1'($urandom % 2);
      send_frame(W * H, 1'b1);
    end
    close_frame("good", 1'b0, 0);

    // Last line one pixel short.
    do_reset();
    send_frame(W * H, 1'b0);
    send_frame(W * H - 1, 1'b0);
    close_frame("short", CHK_EN, CHK_EN ? 1 : 0);

    // One line too many.
    send_frame(W * (H + 1), 1'b0);
    close_frame("overflow", CHK_EN, CHK_EN ? 2 : 0);

    // Error counter saturation.
    for (int f = 0; f < 300; f++) begin
      send_frame(($urandom % 2) ? W * H - 1 : W * H + 1, 1'b0);
    end
    close_frame("saturate", CHK_EN, CHK_EN ? 255 : 0);

    // Reset mid-line with two pixels in flight.
    g_req = 1'b1;
    vs_pulse(1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    step(1'b1, 1'b0, 1'b1, 16'hF800);
    valid_seen = 0;
    step(1'b0, 1'b0, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 16'h1234);
    repeat (6) step(1'b1, 1'b0, 1'b1, 16'($urandom));
    check("rst_flush", valid_seen, 0);
    check("rst_flush_cnt", obs_cnt, 0);
    vs_pulse(1);
    pix_expect("post_rst", 16'hFFFF, 16'hFFFF);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
